// File: rtl/branch_predictor_2lvl_pkg.sv
// Shared definitions for the branch predictor slice: mode encodings and
// saturating-counter helpers reused by every counter table.
package bp_pkg;

  localparam int MODE_LOCAL  = 0;
  localparam int MODE_GSHARE = 1;
  localparam int CTR_W_MAX   = 4;

  function automatic logic [CTR_W_MAX-1:0] ctr_weak_taken(input int ctr_w);
    return CTR_W_MAX'(1) << (ctr_w - 1);
  endfunction

  // Counters are carried at the widest legal width; callers truncate.
  function automatic logic [CTR_W_MAX-1:0] ctr_next(input logic [CTR_W_MAX-1:0] ctr,
                                                    input logic                 taken,
                                                    input int                   ctr_w);
    logic [CTR_W_MAX-1:0] max_v;
    max_v = CTR_W_MAX'((1 << ctr_w) - 1);
    if (taken) return (ctr == max_v) ? ctr : ctr + CTR_W_MAX'(1);
    return (ctr == '0) ? ctr : ctr - CTR_W_MAX'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_2lvl_if.sv
// Pipeline-side signal bundle of the predictor: IF/ID lookup and MEM training.
interface branch_predictor_2lvl_if #(
  parameter int PHT_DEPTH = 8,
  parameter int HIST_W    = 6
);
  logic                 stallD;
  logic                 flushD;
  logic [31:0]          pcF;
  logic                 branchD;
  logic                 pred_takeD;
  logic [PHT_DEPTH-1:0] pht_idxD;
  logic [HIST_W-1:0]    histD;
  logic                 branchM;
  logic                 actual_takeM;
  logic                 pred_takeM;
  logic [31:0]          pcM;
  logic [PHT_DEPTH-1:0] pht_idxM;
  logic [HIST_W-1:0]    histM;

  modport slave (
    input  stallD, flushD, pcF, branchD,
    input  branchM, actual_takeM, pred_takeM, pcM, pht_idxM, histM,
    output pred_takeD, pht_idxD, histD
  );

  modport master (
    output stallD, flushD, pcF, branchD,
    output branchM, actual_takeM, pred_takeM, pcM, pht_idxM, histM,
    input  pred_takeD, pht_idxD, histD
  );
endinterface

// File: rtl/branch_predictor_2lvl_pht.sv
// Pattern history table: 2^DEPTH saturating counters, combinational read,
// synchronous update. Reads see the pre-update value in a collision cycle.
module bp_pht
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] i_rd_idx,
  output logic [CTR_W-1:0] o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [DEPTH-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  logic [CTR_W-1:0]     r_ctr [2**DEPTH];
  logic [CTR_W_MAX-1:0] w_cur;
  logic [CTR_W_MAX-1:0] w_nxt;

  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_cur    = CTR_W_MAX'(r_ctr[i_wr_idx]);
  assign w_nxt    = ctr_next(w_cur, i_wr_taken, CTR_W);

  for (genvar g = 0; g < 2**DEPTH; g++) begin : g_ctr
    always_ff @(posedge clk) begin
      if (rst)
        r_ctr[g] <= CTR_W'(ctr_weak_taken(CTR_W));
      else if (i_wr_en && (i_wr_idx == DEPTH'(g)))
        r_ctr[g] <= CTR_W'(w_nxt);
    end
  end

endmodule

// File: rtl/branch_predictor_2lvl.sv
// Two-level direction predictor: local (per-PC BHT) or gshare (speculative GHR)
// history XORed with the PC to index a shared PHT; lookup in IF, train in MEM.
module branch_predictor_2lvl
  import bp_pkg::*;
#(
  parameter int MODE      = 0,
  parameter int BHT_DEPTH = 10,
  parameter int HIST_W    = 6,
  parameter int PHT_DEPTH = 8,
  parameter int CTR_W     = 2
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_2lvl_if.slave bus
);

  logic [HIST_W-1:0]    w_hist_F;
  logic [PHT_DEPTH-1:0] w_idx_F;
  logic [CTR_W-1:0]     w_ctr_F;
  logic                 w_pred_F;
  logic                 w_pred_takeD;
  logic                 r_pred;
  logic [PHT_DEPTH-1:0] r_idx;
  logic [HIST_W-1:0]    r_hist;
  logic                 w_unused;

  assign w_idx_F  = PHT_DEPTH'(w_hist_F) ^ bus.pcF[PHT_DEPTH+1:2];
  assign w_pred_F = w_ctr_F[CTR_W-1];

  bp_pht #(.DEPTH(PHT_DEPTH), .CTR_W(CTR_W)) u_pht (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_idx_F),
    .o_rd_ctr   (w_ctr_F),
    .i_wr_en    (bus.branchM),
    .i_wr_idx   (bus.pht_idxM),
    .i_wr_taken (bus.actual_takeM)
  );

  // Snapshot of what predicted, so MEM trains the exact same entry.
  always_ff @(posedge clk) begin
    if (rst || bus.flushD) begin
      r_pred <= 1'b0;
      r_idx  <= '0;
      r_hist <= '0;
    end else if (!bus.stallD) begin
      r_pred <= w_pred_F;
      r_idx  <= w_idx_F;
      r_hist <= w_hist_F;
    end
  end

  assign w_pred_takeD   = bus.branchD & r_pred;
  assign bus.pred_takeD = w_pred_takeD;
  assign bus.pht_idxD   = r_idx;
  assign bus.histD      = r_hist;

  if (MODE == MODE_LOCAL) begin : g_local
    logic [HIST_W-1:0]    r_bht [2**BHT_DEPTH];
    logic [BHT_DEPTH-1:0] w_bht_rd;
    logic [BHT_DEPTH-1:0] w_bht_wr;

    assign w_bht_rd = bus.pcF[BHT_DEPTH+1:2];
    assign w_bht_wr = bus.pcM[BHT_DEPTH+1:2];
    assign w_hist_F = r_bht[w_bht_rd];

    for (genvar g = 0; g < 2**BHT_DEPTH; g++) begin : g_bht
      always_ff @(posedge clk) begin
        if (rst)
          r_bht[g] <= '0;
        else if (bus.branchM && (w_bht_wr == BHT_DEPTH'(g)))
          r_bht[g] <= {r_bht[g][HIST_W-2:0], bus.actual_takeM};
      end
    end
  end else begin : g_gshare
    logic [HIST_W-1:0] r_ghr;
    logic              w_mispredict;

    assign w_mispredict = bus.branchM & (bus.actual_takeM != bus.pred_takeM);
    assign w_hist_F     = r_ghr;

    // Mispredict repair rebuilds from the snapshot and wins over speculation.
    always_ff @(posedge clk) begin
      if (rst)
        r_ghr <= '0;
      else if (w_mispredict)
        r_ghr <= {bus.histM[HIST_W-2:0], bus.actual_takeM};
      else if (bus.branchD && !bus.stallD && !bus.flushD)
        r_ghr <= {r_ghr[HIST_W-2:0], w_pred_takeD};
    end
  end

  assign w_unused = ^{bus.pcF, bus.pcM, bus.pred_takeM, bus.histM};

endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// Bench for branch_predictor_2lvl: a local-mode and a gshare-mode instance
// driven in lockstep and checked against an array-based reference model.
module tb_branch_predictor_2lvl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD, flushD, branchD, branchM, actual_takeM, pred_takeM;
  logic [31:0] pcF, pcM;
  logic [7:0]  pht_idxM;
  logic [5:0]  histM;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor_2lvl_if #(.PHT_DEPTH(8), .HIST_W(6)) if_l ();
  branch_predictor_2lvl_if #(.PHT_DEPTH(8), .HIST_W(6)) if_g ();

  assign if_l.stallD = stallD;        assign if_g.stallD = stallD;
  assign if_l.flushD = flushD;        assign if_g.flushD = flushD;
  assign if_l.pcF = pcF;              assign if_g.pcF = pcF;
  assign if_l.branchD = branchD;      assign if_g.branchD = branchD;
  assign if_l.branchM = branchM;      assign if_g.branchM = branchM;
  assign if_l.actual_takeM = actual_takeM; assign if_g.actual_takeM = actual_takeM;
  assign if_l.pred_takeM = pred_takeM;     assign if_g.pred_takeM = pred_takeM;
  assign if_l.pcM = pcM;              assign if_g.pcM = pcM;
  assign if_l.pht_idxM = pht_idxM;    assign if_g.pht_idxM = pht_idxM;
  assign if_l.histM = histM;          assign if_g.histM = histM;

  branch_predictor_2lvl #(.MODE(0), .BHT_DEPTH(10), .HIST_W(6), .PHT_DEPTH(8), .CTR_W(2))
    u_dut_l (.clk(clk), .rst(rst), .bus(if_l));
  branch_predictor_2lvl #(.MODE(1), .BHT_DEPTH(10), .HIST_W(6), .PHT_DEPTH(8), .CTR_W(2))
    u_dut_g (.clk(clk), .rst(rst), .bus(if_g));

  // Reference model: plain integer tables.
  int m_pht_l [256];
  int m_pht_g [256];
  int m_bht   [1024];
  int m_ghr;
  int ml_pred, ml_idx, ml_hist;
  int mg_pred, mg_idx, mg_hist;

  task automatic model_edge();
    int hl, il, pl, hg, ig, pg, spec_bit, a, bi;
    if (rst) begin
      for (int i = 0; i < 256; i++) begin m_pht_l[i] = 2; m_pht_g[i] = 2; end
      for (int i = 0; i < 1024; i++) m_bht[i] = 0;
      m_ghr = 0;
      ml_pred = 0; ml_idx = 0; ml_hist = 0;
      mg_pred = 0; mg_idx = 0; mg_hist = 0;
      return;
    end
    hl = m_bht[int'(pcF[11:2])];
    il = (hl ^ int'(pcF[9:2])) % 256;
    pl = (m_pht_l[il] >= 2) ? 1 : 0;
    hg = m_ghr;
    ig = (hg ^ int'(pcF[9:2])) % 256;
    pg = (m_pht_g[ig] >= 2) ? 1 : 0;
    spec_bit = (branchD && mg_pred != 0) ? 1 : 0;
    a = actual_takeM ? 1 : 0;
    if (branchM) begin
      if (a == 1) begin
        if (m_pht_l[pht_idxM] < 3) m_pht_l[pht_idxM]++;
        if (m_pht_g[pht_idxM] < 3) m_pht_g[pht_idxM]++;
      end else begin
        if (m_pht_l[pht_idxM] > 0) m_pht_l[pht_idxM]--;
        if (m_pht_g[pht_idxM] > 0) m_pht_g[pht_idxM]--;
      end
      bi = int'(pcM[11:2]);
      m_bht[bi] = (m_bht[bi] * 2 + a) % 64;
    end
    if (branchM && (actual_takeM != pred_takeM))
      m_ghr = (int'(histM) * 2 + a) % 64;
    else if (branchD && !stallD && !flushD)
      m_ghr = (m_ghr * 2 + spec_bit) % 64;
    if (flushD) begin
      ml_pred = 0; ml_idx = 0; ml_hist = 0;
      mg_pred = 0; mg_idx = 0; mg_hist = 0;
    end else if (!stallD) begin
      ml_pred = pl; ml_idx = il; ml_hist = hl;
      mg_pred = pg; mg_idx = ig; mg_hist = hg;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    stallD = 0; flushD = 0; branchD = 0; branchM = 0; actual_takeM = 0;
    pred_takeM = 0; pcF = '0; pcM = '0; pht_idxM = '0; histM = '0;
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    stallD = 0; flushD = 0; branchM = 0; actual_takeM = 0; pred_takeM = 0;
    pcM = '0; pht_idxM = '0; histM = '0;
    rst = 1; pcF = 32'h0000_1000; branchD = 1;
    step();
    n_checks++;
    if (if_l.pred_takeD !== 1'b0 || if_g.pred_takeD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clear: pred_takeD local=%0b gshare=%0b required 0", if_l.pred_takeD, if_g.pred_takeD);
    end
    rst = 0;
    step();
    n_checks++;
    if (if_l.pred_takeD !== 1'b1 || if_g.pred_takeD !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pred: pred_takeD local=%0b gshare=%0b required 1", if_l.pred_takeD, if_g.pred_takeD);
    end
    n_checks++;
    if (if_l.histD !== 6'h00 || if_g.histD !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_hist: histD local=%0h gshare=%0h required 0", if_l.histD, if_g.histD);
    end
    n_checks++;
    if (if_l.pht_idxD !== 8'h00 || if_g.pht_idxD !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_idx: pht_idxD local=%0h gshare=%0h required 0", if_l.pht_idxD, if_g.pht_idxD);
    end
  endtask

  task automatic test_saturation();
    bit ops  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    bit exps [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    pcF = 32'h14; pcM = 32'hFFC; pht_idxM = 8'h05;
    for (int i = 0; i < 10; i++) begin
      branchD = 0; branchM = 1; actual_takeM = ops[i]; pred_takeM = ops[i];
      step();
      branchM = 0;
      step();
      branchD = 1;
      #1;
      n_checks++;
      if (if_l.pred_takeD !== exps[i] || if_g.pred_takeD !== exps[i]) begin
        n_fail++;
        $display("FAIL saturation[%0d]: pred local=%0b gshare=%0b required %0b", i, if_l.pred_takeD, if_g.pred_takeD, exps[i]);
      end
    end
    branchD = 0;
  endtask

  task automatic test_local_pattern();
    logic p, a;
    logic [5:0] h;
    do_reset();
    pcM = 32'h40;
    for (int i = 0; i < 40; i++) begin
      a = (i % 2 == 0);
      branchM = 0; branchD = 1; pcF = 32'h40;
      step();
      p = if_l.pred_takeD;
      h = if_l.histD;
      if (i >= 20) begin
        n_checks++;
        if (p !== a) begin
          n_fail++;
          $display("FAIL local_pattern_pred[%0d]: got %0b required %0b", i, p, a);
        end
        n_checks++;
        if (h !== 6'h15 && h !== 6'h2A) begin
          n_fail++;
          $display("FAIL local_pattern_bht[%0d]: got %0h required 15 or 2a", i, h);
        end
      end
      branchD = 0; branchM = 1; actual_takeM = a; pred_takeM = p;
      pht_idxM = 8'(ml_idx); histM = 6'(ml_hist);
      step();
    end
    branchM = 0;
  endtask

  task automatic test_ghr_recovery();
    do_reset();
    pcF = 32'h100; branchD = 0;
    step();
    branchD = 1;
    repeat (3) step();
    branchD = 0;
    step();
    n_checks++;
    if (if_g.histD !== 6'h07) begin
      n_fail++;
      $display("FAIL ghr_speculative: histD got %0h required 07", if_g.histD);
    end
    branchD = 1; branchM = 1; histM = 6'h01; actual_takeM = 0; pred_takeM = 1;
    step();
    branchD = 0; branchM = 0;
    step();
    n_checks++;
    if (if_g.histD !== 6'h02) begin
      n_fail++;
      $display("FAIL ghr_recovery: histD got %0h required 02", if_g.histD);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    pcF = 32'h3C0; branchD = 1;
    step();
    stallD = 1;
    for (int i = 0; i < 3; i++) begin
      pcF = 32'($urandom_range(0, 255)) << 2;
      step();
      n_checks++;
      if (if_l.pred_takeD !== 1'b1 || if_l.pht_idxD !== 8'hF0 ||
          if_g.pred_takeD !== 1'b1 || if_g.pht_idxD !== 8'hF0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: local %0b/%0h gshare %0b/%0h required 1/f0", i,
                 if_l.pred_takeD, if_l.pht_idxD, if_g.pred_takeD, if_g.pht_idxD);
      end
    end
    flushD = 1;
    step();
    n_checks++;
    if (if_l.pred_takeD !== 1'b0 || if_l.pht_idxD !== 8'h00 ||
        if_g.pred_takeD !== 1'b0 || if_g.pht_idxD !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_over_stall: local %0b/%0h gshare %0b/%0h required 0/0",
               if_l.pred_takeD, if_l.pht_idxD, if_g.pred_takeD, if_g.pht_idxD);
    end
    stallD = 0; flushD = 0; branchD = 0;
  endtask

  task automatic test_collision();
    do_reset();
    pcF = 32'h40; pcM = 32'hFFC; pht_idxM = 8'h10;
    branchM = 1; actual_takeM = 0; pred_takeM = 0;
    step();
    actual_takeM = 1; pred_takeM = 1;
    step();
    branchD = 1;
    #1;
    n_checks++;
    if (if_l.pred_takeD !== 1'b0 || if_g.pred_takeD !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_read_old: local=%0b gshare=%0b required 0", if_l.pred_takeD, if_g.pred_takeD);
    end
    branchD = 0; branchM = 0;
    step();
    branchD = 1;
    #1;
    n_checks++;
    if (if_l.pred_takeD !== 1'b1 || if_g.pred_takeD !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_next: local=%0b gshare=%0b required 1", if_l.pred_takeD, if_g.pred_takeD);
    end
    branchD = 0;
  endtask

  task automatic test_random();
    logic el, eg;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      stallD       = ($urandom_range(0, 3) == 0);
      flushD       = ($urandom_range(0, 7) == 0);
      branchD      = 1'($urandom);
      branchM      = 1'($urandom);
      actual_takeM = 1'($urandom);
      pred_takeM   = 1'($urandom);
      pcF          = 32'($urandom_range(0, 63)) << 2;
      pcM          = 32'($urandom_range(0, 63)) << 2;
      pht_idxM     = 8'($urandom_range(0, 63));
      histM        = 6'($urandom);
      step();
      el = branchD & (ml_pred != 0);
      eg = branchD & (mg_pred != 0);
      n_checks++;
      if (if_l.pred_takeD !== el) begin
        n_fail++;
        $display("FAIL rand_local_pred[%0d]: got %0b required %0b", i, if_l.pred_takeD, el);
      end
      n_checks++;
      if (if_l.pht_idxD !== 8'(ml_idx) || if_l.histD !== 6'(ml_hist)) begin
        n_fail++;
        $display("FAIL rand_local_snap[%0d]: idx/hist got %0h/%0h required %0h/%0h", i,
                 if_l.pht_idxD, if_l.histD, ml_idx, ml_hist);
      end
      n_checks++;
      if (if_g.pred_takeD !== eg) begin
        n_fail++;
        $display("FAIL rand_gshare_pred[%0d]: got %0b required %0b", i, if_g.pred_takeD, eg);
      end
      n_checks++;
      if (if_g.pht_idxD !== 8'(mg_idx) || if_g.histD !== 6'(mg_hist)) begin
        n_fail++;
        $display("FAIL rand_gshare_snap[%0d]: idx/hist got %0h/%0h required %0h/%0h", i,
                 if_g.pht_idxD, if_g.histD, mg_idx, mg_hist);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_local_pattern();
    test_ghr_recovery();
    test_stall_flush();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_2lvl.md
Name: branch_predictor_2lvl

Overview:
- Parametrised two-level conditional-branch direction predictor. Successor to the fixed local-history 2-bit predictor.
- Reads in IF and registers the prediction into ID. Trains in MEM.
- Adds a selectable local or gshare mode, configurable counter width, and index/history snapshots carried down the pipe so training uses the exact entry that predicted.
- In gshare mode it also keeps a speculative global history register (GHR) with mispredict recovery.

Parameters:
- MODE, 0: 0 = local (per-PC history from BHT), 1 = gshare (global history).
- BHT_DEPTH, 10: log2 of BHT entries. BHT is indexed by pc[BHT_DEPTH+1:2] and used only in MODE 0.
- HIST_W, 6: history bits per BHT entry or GHR. Legal range 2..PHT_DEPTH.
- PHT_DEPTH, 8: log2 of PHT entries.
- CTR_W, 2: saturating counter width, legal range 2..4. The prediction is the counter MSB.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stallD  in  1  hold the IF->ID prediction register
- flushD  in  1  clear the IF->ID prediction register
- pcF  in  32  fetch PC
- branchD  in  1  ID instruction is a conditional branch (decoded externally)
- pred_takeD  out  1  predicted taken for the ID branch
- pht_idxD  out  PHT_DEPTH  PHT index used for this prediction (piped to MEM)
- histD  out  HIST_W  history value used for this prediction (piped to MEM)
- branchM  in  1  MEM instruction is a resolved conditional branch
- actual_takeM  in  1  resolved direction
- pred_takeM  in  1  piped pred_takeD
- pcM  in  32  MEM PC
- pht_idxM  in  PHT_DEPTH  piped pht_idxD
- histM  in  HIST_W  piped histD

Behaviour:
- Reset, on the rst clock edge:
  - every PHT counter is set to weakly taken, value 2^(CTR_W-1);
  - every BHT entry is set to 0;
  - GHR is set to 0;
  - pred_takeD, pht_idxD and histD are 0 from the next cycle.
- Reset mid-operation discards all history. No partial-state retention.
- IF (combinational):
  - hist_F = BHT[pcF[BHT_DEPTH+1:2]] in MODE 0, GHR in MODE 1.
  - idx_F = zero-extended hist_F XOR pcF[PHT_DEPTH+1:2].
  - pred_F = MSB of PHT[idx_F].
- IF->ID register, holding {pred_F, idx_F, hist_F}:
  - cleared on rst or flushD;
  - held when stallD = 1;
  - otherwise captured each cycle.
  - flushD has priority over stallD.
- Outputs: pred_takeD = branchD AND the registered pred. pht_idxD and histD are the register contents, unmasked.
- PHT training, only when branchM = 1:
  - PHT[pht_idxM] increments if actual_takeM, saturating at 2^CTR_W-1;
  - otherwise it decrements, saturating at 0.
  - The index is never recomputed from pcM.
- BHT training (MODE 0), when branchM = 1: BHT[pcM[BHT_DEPTH+1:2]] <= {old[HIST_W-2:0], actual_takeM}.
- GHR (MODE 1), priority order:
  1. Mispredict: branchM & (actual_takeM != pred_takeM) sets GHR <= {histM[HIST_W-2:0], actual_takeM}.
  2. Else speculative update: branchD & ~stallD & ~flushD shifts in pred_takeD.
  3. Else hold.
- In MODE 0 the GHR is unused and constant 0. The BHT is not instantiated in MODE 1.
- Same-cycle read/write collision on one PHT or BHT entry: the IF read returns the pre-write value (read-before-write); the write lands at the edge.
- Latency: a PHT update in cycle N is visible to IF reads from cycle N+1.
- No handshake. Training is fire-and-forget, one update per cycle maximum.

Decomposition:
- Shared package bp_pkg holds:
  - MODE_LOCAL = 0 and MODE_GSHARE = 1;
  - the function ctr_weak_taken(CTR_W);
  - the saturating next-state function ctr_next(ctr, taken, CTR_W).
- One sub-module, bp_pht: a PHT_DEPTH-deep array of CTR_W counters with one combinational read port and one synchronous update port. It is reusable by a future tournament chooser.
- BHT, GHR and the pipe register stay in the top.

Test Plan:
- Reset then read: assert rst for 1 cycle, pcF = 0x0000_1000, branchD = 1 -> next cycle pred_takeD = 1 (counter 2 of 0..3), histD = 0, pht_idxD = 0x00 (pcF[9:2] = 0x00).
- Saturation, CTR_W = 2: train idx 0x05 not-taken 3 times -> counter 0 and pred 0. One taken -> 1, still not-taken. Two more taken -> 3, then a further taken stays 3.
- Local pattern, MODE 0: a single branch at pcM = 0x0000_0040 resolves alternating T,N (period 2) for 40 iterations -> after warm-up, prediction accuracy on the final 20 is 100%, and its BHT entry cycles 0x15/0x2A.
- GHR recovery, MODE 1: speculatively shift three predicted-taken branches from GHR = 0 -> GHR = 0x07. Then a mispredict in MEM with histM = 0x01, actual = 0 -> GHR = 0x02 next cycle. The same-cycle D update is ignored.
- Stall/flush: with stallD = 1 for 3 cycles while pcF changes, pred_takeD/pht_idxD are held. Assert flushD and stallD together -> pred_takeD = 0, pht_idxD = 0 next cycle.
- Collision: in the same cycle, PHT[0x10] = 1 is trained taken and read by IF -> registered pred = 0. In the following cycle, re-reading 0x10 gives pred = 1.
